gps_emu_cfg_scheduler: RTL

// - Configuration scheduler for the multi-satellite GPS emulator datapath.
// - Takes per-satellite writes (doppler freq, gain, C/A select) and noise gain from a host port into shadow registers.
// - Copies them into the emulator inputs atomically, aligned to the 1 ms C/A code epoch, so no channel changes mid-code-period.
// - Generates the epoch timebase and the code-generator restart pulse.

---
 rtl/gps_emu_cfg_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/gps_emu_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gps_emu_cfg_scheduler
// Description : Host-side configuration scheduler for the multi-satellite GPS
//               emulator. Host writes land in shadow registers and are copied
//               to the active emulator inputs atomically: immediately when
//               stopped, or on the 1 ms C/A epoch boundary while running.
//               Also generates the epoch timebase and the code restart pulse.
//               Optional feature macro: GPS_EMU_DOPPLER_RAMP_EN (per-satellite
//               doppler rate applied on every epoch strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module gps_emu_cfg_scheduler #(
    parameter int NSAT       = 4,
    parameter int EPOCH_CLKS = 102300
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      run,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [2:0]                                cfg_sel,
    input  logic [((NSAT > 1) ? $clog2(NSAT) : 1)-1:0] cfg_sat,
    input  logic [31:0]                               cfg_data,
    input  logic                                      commit_req,
    output logic                                      commit_pending,
    output logic                                      cfg_err,
    output logic                                      commit_ovr,
    output logic                                      epoch_strobe,
    output logic                                      code_restart,
    output logic [32*NSAT-1:0]                        freq,
    output logic [16*NSAT-1:0]                        gain,
    output logic [6*NSAT-1:0]                         ca_sel,
    output logic [15:0]                               noise_gain
);

    localparam int                 c_CNT_W    = (EPOCH_CLKS > 1) ? $clog2(EPOCH_CLKS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(EPOCH_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] S_STOPPED = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_RUNNING = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_epoch_cnt;
    logic               r_pending;
    logic               r_err;
    logic               r_ovr;

    logic [31:0] r_sh_freq  [NSAT];
    logic [15:0] r_sh_gain  [NSAT];
    logic [5:0]  r_sh_ca    [NSAT];
    logic [15:0] r_sh_noise;
    logic [31:0] r_act_freq [NSAT];
    logic [15:0] r_act_gain [NSAT];
    logic [5:0]  r_act_ca   [NSAT];
    logic [15:0] r_act_noise;
`ifdef GPS_EMU_DOPPLER_RAMP_EN
    logic [31:0] r_sh_rate  [NSAT];
    logic [31:0] r_act_rate [NSAT];
`endif

    logic w_wr;
    logic w_sat_ok;
    logic w_bad;
    logic w_accept;
    logic w_live;
    logic w_apply;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_STOPPED;
        else       r_state <= w_state_next;
    end

    // Next-state: START is a single-cycle restart step on the way to RUNNING
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_STOPPED: if (run) w_state_next = S_START;
            S_START:            w_state_next = S_RUNNING;
            S_RUNNING: if (!run) w_state_next = S_STOPPED;
            default:            w_state_next = S_STOPPED;
        endcase
    end

    // FSM outputs: restart pulse, epoch strobe, write backpressure
    always_comb begin
        code_restart = (r_state == S_START);
        epoch_strobe = (r_state == S_RUNNING) && (r_epoch_cnt == c_CNT_LAST);
        cfg_ready    = !r_pending;
    end

    // Epoch counter: held at zero unless running, wraps every epoch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                   r_epoch_cnt <= '0;
        else if (r_state != S_RUNNING)               r_epoch_cnt <= '0;
        else if (r_epoch_cnt == c_CNT_LAST)          r_epoch_cnt <= '0;
        else                                         r_epoch_cnt <= r_epoch_cnt + c_CNT_ONE;
    end

    // Write decode: rejected writes still handshake but never touch the shadow
    always_comb begin
        w_wr     = cfg_valid & cfg_ready;
        w_sat_ok = (int'(cfg_sat) < NSAT);
        w_bad    = 1'b0;
        case (cfg_sel)
            3'd0, 3'd1: w_bad = !w_sat_ok;
            3'd2:       w_bad = !w_sat_ok || (cfg_data[5:0] > 6'd35);
            3'd3:       w_bad = 1'b0;
`ifdef GPS_EMU_DOPPLER_RAMP_EN
            3'd4:       w_bad = !w_sat_ok;
`else
            3'd4:       w_bad = 1'b1;
`endif
            default:    w_bad = 1'b1;
        endcase
        w_accept = w_wr & !w_bad;
    end

    // Commit decision: immediate when stopped (including a leftover armed
    // commit after run drops), otherwise only on an epoch strobe with a
    // commit already armed, so a request on the strobe cycle waits an epoch
    always_comb begin
        w_live  = (r_state != S_STOPPED);
        w_apply = ((r_state == S_STOPPED) && (commit_req || r_pending)) ||
                  (epoch_strobe && r_pending);
    end

    // Commit arm flag and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_apply)                              r_pending <= 1'b0;
            else if (w_live && commit_req && !r_pending) r_pending <= 1'b1;
            if (w_wr && w_bad)                        r_err     <= 1'b1;
            if (commit_req && r_pending)              r_ovr     <= 1'b1;
        end
    end

    // Shadow registers take accepted host writes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSAT; i++) begin
                r_sh_freq[i] <= '0;
                r_sh_gain[i] <= '0;
                r_sh_ca[i]   <= 6'(i);
`ifdef GPS_EMU_DOPPLER_RAMP_EN
                r_sh_rate[i] <= '0;
`endif
            end
            r_sh_noise <= '0;
        end else if (w_accept) begin
            case (cfg_sel)
                3'd0: r_sh_freq[cfg_sat] <= cfg_data;
                3'd1: r_sh_gain[cfg_sat] <= cfg_data[15:0];
                3'd2: r_sh_ca[cfg_sat]   <= cfg_data[5:0];
                3'd3: r_sh_noise         <= cfg_data[15:0];
`ifdef GPS_EMU_DOPPLER_RAMP_EN
                3'd4: r_sh_rate[cfg_sat] <= cfg_data;
`endif
                default: ;
            endcase
        end
    end

    // Active registers: whole shadow set on commit; optional doppler ramp on
    // strobes without a commit (a committed freq overrides that epoch's step)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSAT; i++) begin
                r_act_freq[i] <= '0;
                r_act_gain[i] <= '0;
                r_act_ca[i]   <= 6'(i);
`ifdef GPS_EMU_DOPPLER_RAMP_EN
                r_act_rate[i] <= '0;
`endif
            end
            r_act_noise <= '0;
        end else if (w_apply) begin
            for (int i = 0; i < NSAT; i++) begin
                r_act_freq[i] <= r_sh_freq[i];
                r_act_gain[i] <= r_sh_gain[i];
                r_act_ca[i]   <= r_sh_ca[i];
`ifdef GPS_EMU_DOPPLER_RAMP_EN
                r_act_rate[i] <= r_sh_rate[i];
`endif
            end
            r_act_noise <= r_sh_noise;
        end
`ifdef GPS_EMU_DOPPLER_RAMP_EN
        else if (epoch_strobe) begin
            for (int i = 0; i < NSAT; i++)
                r_act_freq[i] <= r_act_freq[i] + r_act_rate[i];
        end
`endif
    end

    // Flatten active per-satellite registers onto the output buses
    generate
        for (genvar g = 0; g < NSAT; g++) begin : g_out
            assign freq[32*g +: 32]  = r_act_freq[g];
            assign gain[16*g +: 16]  = r_act_gain[g];
            assign ca_sel[6*g +: 6]  = r_act_ca[g];
        end
    endgenerate

    assign noise_gain     = r_act_noise;
    assign commit_pending = r_pending;
    assign cfg_err        = r_err;
    assign commit_ovr     = r_ovr;

endmodule
`default_nettype wire
